jogo_desafio_memoria: RTL and testbench

Top-level Simon-style memory game. It replays a growing LED sequence from a 16×4 RAM, checks the player's button presses against it, and then accepts one new press that extends the sequence for the next round. The game ends in win, loss or timeout. Controller FSM, datapath (counters, RAM, registers, timers) and 7-segment debug decoders all sit inside this block.

---
 rtl/jogo_desafio_memoria_pkg.sv | 35 +++
 rtl/jogo_desafio_memoria_hexa7seg.sv | 31 +++
 rtl/jogo_desafio_memoria_unidade_controle.sv | 113 +++++++++++
 rtl/jogo_desafio_memoria.sv | 146 ++++++++++++++
 tb/tb_jogo_desafio_memoria.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jogo_desafio_memoria_pkg.sv
// Shared definitions for the memory game: FSM encodings and round limits.
package jogo_desafio_memoria_pkg;

    typedef enum logic [4:0] {
        inicial          = 5'b00000,
        preparacao       = 5'b00001,
        inicia_rodada    = 5'b00010,
        mostra_led       = 5'b00011,
        proximo_led      = 5'b00100,
        mostra_apagado   = 5'b00101,
        zera_endereco    = 5'b00110,
        espera_jogada    = 5'b00111,
        registra         = 5'b01000,
        compara          = 5'b01001,
        proxima_jogada   = 5'b01010,
        proxima_rodada   = 5'b01100,
        espera_escrita   = 5'b01101,
        registra_escrita = 5'b01110,
        escreve          = 5'b01111,
        fim_ganhou       = 5'b11101,
        fim_perdeu       = 5'b11110,
        fim_timeout      = 5'b11111
    } estado_t;

    localparam int unsigned DADO_W       = 4;
    localparam logic [3:0]  LIMITE_MODO0 = 4'd15;
    localparam logic [3:0]  LIMITE_MODO1 = 4'd7;
    localparam logic [3:0]  DADO_INICIAL = 4'b0001;

    // Last round index for the latched mode (0: 16 rounds, 1: 8 rounds)
    function automatic logic [3:0] ultimo_limite(input logic modo);
        return modo ? LIMITE_MODO1 : LIMITE_MODO0;
    endfunction

endpackage

// File: rtl/jogo_desafio_memoria_hexa7seg.sv
// Hex digit to active-low 7-segment decoder, segment order gfedcba.
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    // Segment lookup
    always_comb begin
        display = 7'b1111111;
        case (hexa)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            4'hF: display = 7'b0001110;
            default: display = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/jogo_desafio_memoria_unidade_controle.sv
// Game controller: sequencing of replay, player checking and sequence extension.
module unidade_controle
    import jogo_desafio_memoria_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    jogar,
    input  logic    jogada,
    input  logic    igual,
    input  logic    endereco_igual_limite,
    input  logic    limite_ultimo,
    input  logic    timeout_en,
    input  logic    fim_led,
    input  logic    fim_apagado,
    input  logic    fim_espera,
    output estado_t estado,
    output logic    zera_timer_c,
    output logic    zera_endereco_c,
    output logic    conta_endereco_c,
    output logic    zera_limite_c,
    output logic    conta_limite_c,
    output logic    registra_jogada_c,
    output logic    escreve_c,
    output logic    carrega_config_c
);

    estado_t Eatual;
    estado_t Eprox;

    assign estado = Eatual;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) Eatual <= inicial;
        else       Eatual <= Eprox;
    end

    // Next state and datapath strobes
    always_comb begin
        Eprox             = Eatual;
        zera_endereco_c   = 1'b0;
        conta_endereco_c  = 1'b0;
        zera_limite_c     = 1'b0;
        conta_limite_c    = 1'b0;
        registra_jogada_c = 1'b0;
        escreve_c         = 1'b0;
        carrega_config_c  = 1'b0;
        case (Eatual)
            inicial: if (jogar) Eprox = preparacao;
            preparacao: begin
                zera_limite_c    = 1'b1;
                zera_endereco_c  = 1'b1;
                carrega_config_c = 1'b1;
                Eprox            = inicia_rodada;
            end
            inicia_rodada: begin
                zera_endereco_c = 1'b1;
                Eprox           = mostra_led;
            end
            mostra_led: if (fim_led) Eprox = mostra_apagado;
            mostra_apagado: if (fim_apagado)
                Eprox = endereco_igual_limite ? zera_endereco : proximo_led;
            proximo_led: begin
                conta_endereco_c = 1'b1;
                Eprox            = mostra_led;
            end
            zera_endereco: begin
                zera_endereco_c = 1'b1;
                Eprox           = espera_jogada;
            end
            espera_jogada: begin
                if (jogada)                        Eprox = registra;
                else if (timeout_en && fim_espera) Eprox = fim_timeout;
            end
            registra: begin
                registra_jogada_c = 1'b1;
                Eprox             = compara;
            end
            compara: begin
                if (!igual)                      Eprox = fim_perdeu;
                else if (!endereco_igual_limite) Eprox = proxima_jogada;
                else if (limite_ultimo)          Eprox = fim_ganhou;
                else                             Eprox = espera_escrita;
            end
            proxima_jogada: begin
                conta_endereco_c = 1'b1;
                Eprox            = espera_jogada;
            end
            espera_escrita: begin
                if (jogada)                        Eprox = registra_escrita;
                else if (timeout_en && fim_espera) Eprox = fim_timeout;
            end
            registra_escrita: begin
                registra_jogada_c = 1'b1;
                conta_endereco_c  = 1'b1;
                Eprox             = escreve;
            end
            escreve: begin
                escreve_c = 1'b1;
                Eprox     = proxima_rodada;
            end
            proxima_rodada: begin
                conta_limite_c = 1'b1;
                Eprox          = inicia_rodada;
            end
            fim_ganhou, fim_perdeu, fim_timeout: if (jogar) Eprox = preparacao;
            default: Eprox = inicial;
        endcase
        // Every state change restarts the shared cycle timer
        zera_timer_c = (Eprox != Eatual);
    end

endmodule

// File: rtl/jogo_desafio_memoria.sv
// Simon-style memory game: controller, datapath and debug displays.
module jogo_desafio_memoria
    import jogo_desafio_memoria_pkg::*;
#(
    parameter int unsigned T_LED     = 1000,
    parameter int unsigned T_APAGADO = 500,
    parameter int unsigned T_TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic [1:0] configuracao,
    input  logic [3:0] botoes,
    output logic [3:0] leds,
    output logic [2:0] leds_rgb,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic       pronto,
    output logic       db_igual,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_enderecoIgualLimite,
    output logic       db_timeout,
    output logic       db_modo,
    output logic       db_configuracao,
    output logic       db_escrita,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_limite_rodada
);

    localparam int unsigned T_MAX = (T_LED > T_APAGADO)
        ? ((T_LED > T_TIMEOUT) ? T_LED : T_TIMEOUT)
        : ((T_APAGADO > T_TIMEOUT) ? T_APAGADO : T_TIMEOUT);
    localparam int unsigned TIMER_W = $clog2(T_MAX + 1);

    estado_t             estado;
    logic [4:0]          estado_bits;
    logic [3:0]          endereco, limite;
    logic [DADO_W-1:0]   jogada_r, botoes_r, mem_dado;
    logic [DADO_W-1:0]   mem [16];
    logic                modo_r, timeout_en_r;
    logic [TIMER_W-1:0]  timer;
    logic                jogada_c, igual_c, endereco_igual_limite_c;
    logic                zera_timer_c, zera_endereco_c, conta_endereco_c;
    logic                zera_limite_c, conta_limite_c, registra_jogada_c;
    logic                escreve_c, carrega_config_c;

    unidade_controle u_uc (
        .clock                 (clock),
        .reset                 (reset),
        .jogar                 (jogar),
        .jogada                (jogada_c),
        .igual                 (igual_c),
        .endereco_igual_limite (endereco_igual_limite_c),
        .limite_ultimo         (limite == ultimo_limite(modo_r)),
        .timeout_en            (timeout_en_r),
        .fim_led               (timer == TIMER_W'(T_LED - 1)),
        .fim_apagado           (timer == TIMER_W'(T_APAGADO - 1)),
        .fim_espera            (timer == TIMER_W'(T_TIMEOUT - 1)),
        .estado                (estado),
        .zera_timer_c          (zera_timer_c),
        .zera_endereco_c       (zera_endereco_c),
        .conta_endereco_c      (conta_endereco_c),
        .zera_limite_c         (zera_limite_c),
        .conta_limite_c        (conta_limite_c),
        .registra_jogada_c     (registra_jogada_c),
        .escreve_c             (escreve_c),
        .carrega_config_c      (carrega_config_c)
    );

    // Counters, jogada/config registers, button history and cycle timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco     <= '0;
            limite       <= '0;
            jogada_r     <= '0;
            botoes_r     <= '0;
            modo_r       <= 1'b0;
            timeout_en_r <= 1'b0;
            timer        <= '0;
        end else begin
            botoes_r <= botoes;
            if (zera_endereco_c)       endereco <= '0;
            else if (conta_endereco_c) endereco <= endereco + 4'd1;
            if (zera_limite_c)         limite <= '0;
            else if (conta_limite_c)   limite <= limite + 4'd1;
            // botoes_r holds the press that caused the jump into registra*
            if (registra_jogada_c)     jogada_r <= botoes_r;
            if (carrega_config_c) begin
                modo_r       <= configuracao[0];
                timeout_en_r <= configuracao[1];
            end
            if (zera_timer_c)          timer <= '0;
            else if (timer != '1)      timer <= timer + TIMER_W'(1);
        end
    end

    // Sequence RAM; word 0 is the fixed first step and is never written
    always_ff @(posedge clock) begin
        if (escreve_c && endereco != 4'd0) mem[endereco] <= jogada_r;
    end

    assign mem_dado                = (endereco == 4'd0) ? DADO_INICIAL : mem[endereco];
    assign jogada_c                = (|botoes) & ~(|botoes_r);
    assign igual_c                 = (jogada_r == mem_dado);
    assign endereco_igual_limite_c = (endereco == limite);
    assign estado_bits             = estado;

    assign leds    = (estado == mostra_led) ? mem_dado : '0;
    assign ganhou  = (estado == fim_ganhou);
    assign perdeu  = (estado == fim_perdeu);
    assign timeout = (estado == fim_timeout);
    assign pronto  = ganhou | perdeu | timeout;

    // Status colour {R,G,B}
    always_comb begin
        leds_rgb = 3'b000;
        case (estado)
            fim_ganhou:                 leds_rgb = 3'b010;
            fim_perdeu, fim_timeout:    leds_rgb = 3'b100;
            inicia_rodada, mostra_led,
            proximo_led, mostra_apagado: leds_rgb = 3'b001;
            default:                    leds_rgb = 3'b000;
        endcase
    end

    assign db_igual               = igual_c;
    assign db_clock               = clock;
    assign db_iniciar             = jogar;
    assign db_enderecoIgualLimite = endereco_igual_limite_c;
    assign db_timeout             = timeout;
    assign db_modo                = modo_r;
    assign db_configuracao        = timeout_en_r;
    assign db_escrita             = escreve_c;

    hexa7seg u_hex_contagem (.hexa(endereco),         .display(db_contagem));
    hexa7seg u_hex_memoria  (.hexa(mem_dado),         .display(db_memoria));
    hexa7seg u_hex_estado   (.hexa(estado_bits[3:0]), .display(db_estado));
    hexa7seg u_hex_jogada   (.hexa(jogada_r),         .display(db_jogadafeita));
    hexa7seg u_hex_limite   (.hexa(limite),           .display(db_limite_rodada));

endmodule

// File: tb/tb_jogo_desafio_memoria.sv
// Scoreboard bench for the memory game: player model drives, monitor checks replays and endings.
module tb_jogo_desafio_memoria;

    localparam int unsigned T_LED     = 4;
    localparam int unsigned T_APAGADO = 3;
    localparam int unsigned T_TIMEOUT = 20;

    logic       clock = 1'b0;
    logic       reset, jogar;
    logic [1:0] configuracao;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic [2:0] leds_rgb;
    logic       ganhou, perdeu, timeout, pronto;
    logic       db_igual, db_clock, db_iniciar, db_enderecoIgualLimite;
    logic       db_timeout, db_modo, db_configuracao, db_escrita;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite_rodada;

    always #5 clock = ~clock;

    jogo_desafio_memoria #(
        .T_LED(T_LED), .T_APAGADO(T_APAGADO), .T_TIMEOUT(T_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
        .botoes(botoes), .leds(leds), .leds_rgb(leds_rgb), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .pronto(pronto), .db_igual(db_igual),
        .db_clock(db_clock), .db_iniciar(db_iniciar),
        .db_enderecoIgualLimite(db_enderecoIgualLimite), .db_timeout(db_timeout),
        .db_modo(db_modo), .db_configuracao(db_configuracao), .db_escrita(db_escrita),
        .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
        .db_jogadafeita(db_jogadafeita), .db_limite_rodada(db_limite_rodada)
    );

    typedef struct packed {
        logic       g, p, t;
        logic [2:0] rgb;
        logic [3:0] est;
        logic [3:0] lim;
    } fim_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_leds_q[$];
    fim_t       exp_fim_q[$];

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    task automatic falha_espera(input string nome);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", nome, $time);
    endtask

    // Monitor: LED replay values/durations and game endings
    logic [3:0] leds_prev   = '0;
    logic       pronto_prev = 1'b0;
    int         lit         = 0;
    always @(negedge clock) begin
        fim_t f;
        if (reset) begin
            leds_prev   = '0;
            pronto_prev = 1'b0;
            lit         = 0;
        end else begin
            if (leds != 4'd0 && leds_prev == 4'd0) begin
                if (exp_leds_q.size() == 0) check("led_unexpected", 32'(leds), 32'd0);
                else check("led_value", 32'(leds), 32'(exp_leds_q.pop_front()));
                check("rgb_showing", 32'(leds_rgb), 32'd1);
                lit = 1;
            end else if (leds != 4'd0) begin
                lit++;
            end else if (leds_prev != 4'd0) begin
                check("led_duration", 32'(lit), 32'(T_LED));
            end
            if (pronto && !pronto_prev) begin
                if (exp_fim_q.size() == 0) begin
                    check("end_unexpected", 32'(pronto), 32'd0);
                end else begin
                    f = exp_fim_q.pop_front();
                    check("ganhou", 32'(ganhou), 32'(f.g));
                    check("perdeu", 32'(perdeu), 32'(f.p));
                    check("timeout", 32'(timeout), 32'(f.t));
                    check("db_timeout", 32'(db_timeout), 32'(f.t));
                    check("rgb_end", 32'(leds_rgb), 32'(f.rgb));
                    check("estado_end", 32'(db_estado), 32'(seg(f.est)));
                    check("limite_end", 32'(db_limite_rodada), 32'(seg(f.lim)));
                end
            end
            leds_prev   = leds;
            pronto_prev = pronto;
        end
    end

    task automatic push_fim(input logic g, input logic p, input logic t,
                            input logic [2:0] rgb, input logic [3:0] est, input logic [3:0] lim);
        fim_t f;
        f.g = g; f.p = p; f.t = t; f.rgb = rgb; f.est = est; f.lim = lim;
        exp_fim_q.push_back(f);
    endtask

    task automatic espera_estado(input logic [3:0] e);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (db_estado == seg(e) && !pronto) return;
        end
        falha_espera("wait_state");
    endtask

    task automatic espera_pronto();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (pronto) return;
        end
        falha_espera("wait_end");
    endtask

    task automatic inicia_jogo();
        @(negedge clock);
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    task automatic pressiona(input logic [3:0] v, input logic [3:0] e);
        espera_estado(e);
        botoes = v;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        botoes = '0;
        @(negedge clock);
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    task automatic checa_repouso(input string tag);
        check({tag, "_ganhou"}, 32'(ganhou), 32'd0);
        check({tag, "_perdeu"}, 32'(perdeu), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_pronto"}, 32'(pronto), 32'd0);
        check({tag, "_leds"}, 32'(leds), 32'd0);
        check({tag, "_rgb"}, 32'(leds_rgb), 32'd0);
        check({tag, "_estado"}, 32'(db_estado), 32'(seg(4'h0)));
        check({tag, "_contagem"}, 32'(db_contagem), 32'(seg(4'h0)));
        check({tag, "_limite"}, 32'(db_limite_rodada), 32'(seg(4'h0)));
        check({tag, "_jogada"}, 32'(db_jogadafeita), 32'(seg(4'h0)));
    endtask

    task automatic fecha_jogo(input logic [1:0] cfg);
        repeat (2) @(negedge clock);
        check("pronto_hold", 32'(pronto), 32'd1);
        check("db_modo", 32'(db_modo), 32'(cfg[0]));
        check("db_configuracao", 32'(db_configuracao), 32'(cfg[1]));
    endtask

    // Player model: sequence grows by one press per round; optional wrong press at step 1
    task automatic joga(input logic [1:0] cfg, input int rodada_erro, input bit ciclico);
        logic [3:0] seq [16];
        logic [3:0] errado;
        int         ult;
        int         cnt;
        ult = cfg[0] ? 7 : 15;
        for (int i = 0; i < 16; i++)
            seq[i] = ciclico ? 4'(1 << (i % 4)) : 4'(1 << $urandom_range(0, 3));
        seq[0] = 4'b0001;
        configuracao = cfg;
        exp_leds_q.push_back(seq[0]);
        inicia_jogo();
        for (int r = 0; r <= ult; r++) begin
            for (int k = 0; k <= r; k++) begin
                if (r == rodada_erro && k == 1) begin
                    errado = {seq[k][2:0], seq[k][3]};
                    push_fim(1'b0, 1'b1, 1'b0, 3'b100, 4'hE, 4'(r));
                    espera_estado(4'h7);
                    botoes = errado;
                    @(negedge clock);
                    botoes = '0;
                    cnt = 1;
                    while (!pronto && cnt < 20) begin
                        @(negedge clock);
                        cnt++;
                    end
                    check("lose_latency", 32'(cnt), 32'd3);
                    check("wrong_jogada", 32'(db_jogadafeita), 32'(seg(errado)));
                    fecha_jogo(cfg);
                    return;
                end
                if (r == ult && k == r) push_fim(1'b1, 1'b0, 1'b0, 3'b010, 4'hD, 4'(ult));
                pressiona(seq[k], 4'h7);
            end
            if (r < ult) begin
                for (int k = 0; k <= r + 1; k++) exp_leds_q.push_back(seq[k]);
                pressiona(seq[r + 1], 4'hD);
            end
        end
        espera_pronto();
        fecha_jogo(cfg);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "global time limit reached");
    end

    initial begin
        int cnt;
        reset        = 1'b1;
        jogar        = 1'b0;
        configuracao = 2'b00;
        botoes       = '0;
        repeat (3) @(negedge clock);
        checa_repouso("reset");
        reset = 1'b0;

        // Full 16-round win with the cyclic pattern, then a wrong press in round 2
        joga(2'b00, -1, 1'b1);
        joga(2'b00, 2, 1'b1);

        // Timeout enabled: no press in espera_jogada
        configuracao = 2'b10;
        exp_leds_q.push_back(4'b0001);
        push_fim(1'b0, 1'b0, 1'b1, 3'b100, 4'hF, 4'h0);
        inicia_jogo();
        espera_estado(4'h7);
        check("cfg_timeout_en", 32'(db_configuracao), 32'd1);
        check("cfg_modo", 32'(db_modo), 32'd0);
        cnt = 0;
        while (!pronto && cnt < 4 * T_TIMEOUT) begin
            @(negedge clock);
            cnt++;
        end
        check("timeout_latency", 32'(cnt), 32'(T_TIMEOUT));
        repeat (2) @(negedge clock);

        // Timeout disabled: waits indefinitely, then reset in the middle of a replay
        configuracao = 2'b00;
        exp_leds_q.push_back(4'b0001);
        inicia_jogo();
        espera_estado(4'h7);
        repeat (3 * T_TIMEOUT) @(negedge clock);
        check("no_timeout_pronto", 32'(pronto), 32'd0);
        check("no_timeout_estado", 32'(db_estado), 32'(seg(4'h7)));
        pressiona(4'b0001, 4'h7);
        exp_leds_q.push_back(4'b0001);
        exp_leds_q.push_back(4'b0010);
        pressiona(4'b0010, 4'hD);
        cnt = 0;
        while (leds != 4'b0010 && cnt < 200) begin
            @(negedge clock);
            cnt++;
        end
        check("led_before_reset", 32'(leds), 32'd2);
        reset = 1'b1;
        #1;
        checa_repouso("reset_mid");
        exp_leds_q.delete();
        @(negedge clock);
        reset = 1'b0;

        // Mode 1 (8 rounds) with random presses, then a random early loss
        joga(2'b01, -1, 1'b0);
        joga(2'b00, int'($urandom_range(1, 4)), 1'b0);

        repeat (5) @(negedge clock);
        check("led_queue_empty", 32'(exp_leds_q.size()), 32'd0);
        check("end_queue_empty", 32'(exp_fim_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
